pc_unit_ras: RTL

- Next-generation program counter for the core.
- Single-clock, parametrised in address width, instruction step and return-address-stack (RAS) depth.
- Adds signed relative branches, call/return with a hardware RAS, alignment enforcement and sticky fault flags.
- Sits between the control FSM (supplies pc_latch_data, pc_ctl) and the fetch/register-file datapath (supplies imm, sr1_val; consumes pc_out).

---
 rtl/pc_unit_ras_if.sv | 46 ++++
 rtl/pc_unit_ras.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/pc_unit_ras_if.sv
// Request/status bundle between the control FSM, the datapath and the PC unit.
// The master drives the next-PC request; the slave (PC unit) returns PC and status.
interface pc_unit_ras_if #(
    parameter int PC_BITS  = 6,
    parameter int CNT_BITS = 3
);
    logic                pc_latch_data;
    logic [2:0]          pc_ctl;
    logic [PC_BITS-1:0]  imm;
    logic [PC_BITS-1:0]  sr1_val;
    logic                clear_flags;
    logic [PC_BITS-1:0]  pc_out;
    logic [CNT_BITS-1:0] ras_count;
    logic                ras_overflow;
    logic                ras_underflow;
    logic                misalign;
    logic                illegal_ctl;

    modport master (
        output pc_latch_data,
        output pc_ctl,
        output imm,
        output sr1_val,
        output clear_flags,
        input  pc_out,
        input  ras_count,
        input  ras_overflow,
        input  ras_underflow,
        input  misalign,
        input  illegal_ctl
    );

    modport slave (
        input  pc_latch_data,
        input  pc_ctl,
        input  imm,
        input  sr1_val,
        input  clear_flags,
        output pc_out,
        output ras_count,
        output ras_overflow,
        output ras_underflow,
        output misalign,
        output illegal_ctl
    );
endinterface

// File: rtl/pc_unit_ras.sv
// Program counter with relative branches, call/return via a circular
// return-address stack, alignment enforcement and sticky fault flags.
module pc_unit_ras #(
    parameter int PC_BITS   = 6,
    parameter int STEP      = 2,
    parameter int RAS_DEPTH = 4,
    parameter int RESET_VEC = 0
) (
    input  logic         clka,
    input  logic         reset,
    pc_unit_ras_if.slave bus
);
    localparam int CW = $clog2(RAS_DEPTH + 1);
    localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam logic [PC_BITS-1:0] AMASK  = PC_BITS'(STEP - 1);
    localparam logic [PC_BITS-1:0] STEP_V = PC_BITS'(STEP);
    localparam logic [PC_BITS-1:0] RST_PC = PC_BITS'(RESET_VEC);
    localparam logic [CW-1:0]      FULL   = CW'(RAS_DEPTH);
    localparam logic [PW-1:0]      LAST   = PW'(RAS_DEPTH - 1);

    logic [PC_BITS-1:0] pc;
    logic [PC_BITS-1:0] ras [RAS_DEPTH];
    logic [PW-1:0]      ptr;
    logic [CW-1:0]      cnt;
    logic               ovf;
    logic               unf;
    logic               mis;
    logic               ill;

    logic               is_inc;
    logic               is_rel;
    logic               is_jmp;
    logic               is_call;
    logic               is_ret;
    logic               is_ill;
    logic [PC_BITS-1:0] pc_seq;
    logic [PC_BITS-1:0] tgt_rel;
    logic [PC_BITS-1:0] raw;
    logic [PC_BITS-1:0] pc_next;
    logic [PW-1:0]      ptr_inc;
    logic [PW-1:0]      ptr_dec;
    logic               ras_full;
    logic               ras_empty;
    logic               chk;
    logic               push;
    logic               pop;
    logic               set_ovf;
    logic               set_unf;
    logic               set_mis;
    logic               set_ill;
    logic               upd;

    assign upd = bus.pc_latch_data;

    always_comb begin
        is_inc    = (bus.pc_ctl == 3'b000);
        is_rel    = (bus.pc_ctl == 3'b001);
        is_jmp    = (bus.pc_ctl == 3'b010);
        is_call   = (bus.pc_ctl == 3'b011);
        is_ret    = (bus.pc_ctl == 3'b100);
        is_ill    = bus.pc_ctl[2] & (bus.pc_ctl[1] | bus.pc_ctl[0]);
        pc_seq    = pc + STEP_V;
        tgt_rel   = pc + bus.imm;
        ras_full  = (cnt == FULL);
        ras_empty = (cnt == '0);
        ptr_inc   = (ptr == LAST) ? '0 : ptr + PW'(1);
        ptr_dec   = (ptr == '0) ? LAST : ptr - PW'(1);
        raw       = pc_seq;
        chk       = 1'b0;
        push      = 1'b0;
        pop       = 1'b0;
        set_ovf   = 1'b0;
        set_unf   = 1'b0;
        set_ill   = 1'b0;
        unique case (1'b1)
            is_inc: raw = pc_seq;
            is_rel: begin
                raw = tgt_rel;
                chk = 1'b1;
            end
            is_jmp: begin
                raw = bus.sr1_val;
                chk = 1'b1;
            end
            is_call: begin
                raw     = tgt_rel;
                chk     = 1'b1;
                push    = 1'b1;
                set_ovf = ras_full;
            end
            is_ret: begin
                if (ras_empty) begin
                    set_unf = 1'b1;
                end else begin
                    raw = ras[ptr];
                    pop = 1'b1;
                end
            end
            is_ill: set_ill = 1'b1;
            default: raw = pc_seq;
        endcase
        // inc and return targets are aligned by construction
        set_mis = chk & (|(raw & AMASK));
        pc_next = raw & ~AMASK;
    end

    always_ff @(posedge clka or negedge reset) begin
        if (!reset) begin
            pc  <= RST_PC;
            ptr <= '0;
            cnt <= '0;
        end else if (upd) begin
            pc <= pc_next;
            if (push) begin
                ptr <= ptr_inc;
                if (!ras_full) cnt <= cnt + CW'(1);
            end else if (pop) begin
                ptr <= ptr_dec;
                cnt <= cnt - CW'(1);
            end
        end
    end

    // set beats clear when both land on the same edge
    always_ff @(posedge clka or negedge reset) begin
        if (!reset) begin
            ovf <= 1'b0;
            unf <= 1'b0;
            mis <= 1'b0;
            ill <= 1'b0;
        end else begin
            ovf <= (ovf & ~bus.clear_flags) | (upd & set_ovf);
            unf <= (unf & ~bus.clear_flags) | (upd & set_unf);
            mis <= (mis & ~bus.clear_flags) | (upd & set_mis);
            ill <= (ill & ~bus.clear_flags) | (upd & set_ill);
        end
    end

    always_ff @(posedge clka) begin
        if (upd && push) ras[ptr_inc] <= pc_seq;
    end

    assign bus.pc_out        = pc;
    assign bus.ras_count     = cnt;
    assign bus.ras_overflow  = ovf;
    assign bus.ras_underflow = unf;
    assign bus.misalign      = mis;
    assign bus.illegal_ctl   = ill;
endmodule
